// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Issues handshaked requests to the
//            instruction memory, buffers returned words together with their
//            PC in a small FIFO, and supports branch redirect with flush of
//            buffered and in-flight instructions.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            imem_req/imem_addr              - fetch request and word address
//            imem_ack/imem_rdata             - accept strobe, same-cycle data
//            inst_valid/inst_data/inst_pc    - buffer head toward decode
//            inst_ready                      - consumer pops the head
//            br_taken/br_pc/br_imm           - redirect request and operands
//            fifo_count                      - occupied buffer entries
//            perf_fetched/perf_flushed       - only with FETCH_PERF_CNT_EN
// Options  : define FETCH_PERF_CNT_EN to add saturating fetch/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              IMM_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          imem_req,
    output logic [XLEN-1:0]               imem_addr,
    input  logic                          imem_ack,
    input  logic [31:0]                   imem_rdata,
    output logic                          inst_valid,
    output logic [31:0]                   inst_data,
    output logic [XLEN-1:0]               inst_pc,
    input  logic                          inst_ready,
    input  logic                          br_taken,
    input  logic [XLEN-1:0]               br_pc,
    input  logic [IMM_W-1:0]              br_imm,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_flushed
`endif
);

    localparam int                c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]   c_RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

    // S_WAIT : live request outstanding, its data will be pushed.
    // S_DROP : request outstanding but superseded by a redirect; the
    //          returning word is thrown away.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [XLEN-1:0]     w_fetch_pc_nxt;
    logic                r_imem_req;
    logic [XLEN-1:0]     r_imem_addr;

    logic [31:0]         r_mem_data [FIFO_DEPTH];
    logic [XLEN-1:0]     r_mem_pc   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_after;

    logic                w_push;
    logic                w_pop;
    logic [XLEN-1:0]     w_imm_ext;
    logic [XLEN-1:0]     w_target_raw;
    logic [XLEN-1:0]     w_target;

    // Branch target: PC of the instruction after the branch plus a signed
    // word offset, forced to word alignment.
    assign w_imm_ext    = XLEN'($signed(br_imm));
    assign w_target_raw = br_pc + XLEN'(4) + (w_imm_ext << 2);
    assign w_target     = {w_target_raw[XLEN-1:2], 2'b00};

    // A redirect overrides every buffer movement in the same cycle.
    assign w_push        = (r_state == S_WAIT) && imem_ack && !br_taken;
    assign w_pop         = (r_count != '0) && inst_ready && !br_taken;
    assign w_count_after = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        if (br_taken) begin
            w_fetch_pc_nxt = w_target;
            // A request that is still open cannot be withdrawn, so its
            // answer must be waited for and discarded.
            w_state_nxt = ((r_state != S_IDLE) && !imem_ack) ? S_DROP : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < c_DEPTH) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
                        // Chain the next request when the buffer, after this
                        // cycle's push/pop, still has room for it.
                        w_state_nxt = (w_count_after < c_DEPTH) ? S_WAIT : S_IDLE;
                    end
                end
                S_DROP: begin
                    // Buffer is empty after the flush, so room is guaranteed.
                    if (imem_ack) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= c_RESET_ADDR;
            r_imem_req  <= 1'b0;
            r_imem_addr <= c_RESET_ADDR;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_imem_req <= (w_state_nxt != S_IDLE);
            // While dropping, the bus must keep showing the superseded
            // address until it is acknowledged.
            if (w_state_nxt != S_DROP) begin
                r_imem_addr <= w_fetch_pc_nxt;
            end
            if (br_taken) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= w_count_after;
            end
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_mem_data[r_rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign fifo_count = r_count;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] w_flush_add;
    logic [32:0] w_flush_sum;

    // Lost work at a redirect: every buffered entry plus a live in-flight
    // request. A request already in S_DROP was counted at the earlier redirect.
    assign w_flush_add = 32'(r_count) + 32'(r_state == S_WAIT);
    assign w_flush_sum = {1'b0, r_perf_flushed} + {1'b0, w_flush_add};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_push && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (br_taken) begin
                r_perf_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`else
    // Performance counters not built.
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation CPU.
- Replaces the free-running PC register and PC+4 / branch-target adder with a handshaked instruction-memory requester, an instruction buffer, and branch redirect/flush.
- Sits between the instruction memory and the decode/control stage.
- Decouples memory latency from the consumer, which pops instructions with a valid/ready handshake.

Parameters:
- XLEN, 32, width of PC and address path.
- RESET_PC, 0, fetch address after reset; low two bits are ignored.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2.
- IMM_W, 16, width of the branch immediate.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  word-aligned fetch address
- imem_ack  in  1  request accepted; imem_rdata is valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- inst_valid  out  1  buffer head is valid
- inst_data  out  32  instruction at the buffer head
- inst_pc  out  XLEN  PC of inst_data
- inst_ready  in  1  consumer takes the head this cycle
- br_taken  in  1  redirect request (branch resolved taken)
- br_pc  in  XLEN  PC of the taken branch
- br_imm  in  IMM_W  signed word offset
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fetch_pc = RESET_PC with bits[1:0] = 0.
  - FIFO empty; state IDLE.
  - imem_req=0, imem_addr=RESET_PC&~3, inst_valid=0, inst_data=0, inst_pc=0, fifo_count=0.
- State machine: IDLE, WAIT, DROP.
  - IDLE: if credit is available, assert imem_req with imem_addr=fetch_pc and go to WAIT.
  - Credit means fifo_count plus outstanding requests is less than FIFO_DEPTH.
  - WAIT: imem_req stays high and imem_addr stays stable until imem_ack.
    - On ack: push {fetch_pc, imem_rdata} and set fetch_pc += 4, wrapping modulo 2^XLEN.
    - Then go to IDLE, or issue the next request back-to-back if credit remains; throughput is one instruction per cycle when ack is held high.
  - DROP: a request was in flight when a redirect occurred.
    - imem_req stays high with the old address; a request is never retracted.
    - The acked data is discarded (no push). Then issue at the new fetch_pc.
- Redirect (br_taken=1 at a clock edge):
  - target = br_pc + 4 + (sign_extend(br_imm) << 2), truncated to XLEN, bits[1:0] forced to 0.
  - Effects at that edge: FIFO flushed (count=0), fetch_pc=target.
  - If in WAIT without ack in the same cycle, go to DROP.
  - If ack arrives in the same cycle, that data is discarded and the next state is IDLE.
  - br_taken has priority over the same-cycle push, pop and ack.
  - br_taken during DROP retargets fetch_pc and stays in DROP.
- Buffer:
  - inst_valid = (fifo_count != 0); inst_data and inst_pc come from the head entry.
  - Pop when inst_valid && inst_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - inst_ready while empty has no effect.
  - The FIFO never overflows because of the credit rule; pointers wrap modulo FIFO_DEPTH.
- Latency: imem_ack at edge N with an empty buffer gives inst_valid=1 after edge N, i.e. visible in cycle N+1.
- Reset asserted mid-transaction: an outstanding request is abandoned, imem_req drops immediately, and a late ack after reset release while in IDLE is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_flushed (32).
  - perf_fetched increments on every push.
  - perf_flushed adds the number of discarded entries plus any dropped in-flight word at each redirect.
  - Both counters reset to 0, saturate at 2^32-1, and are readable in every cycle.
- Not defined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release, imem_ack held at 1, inst_ready=1 → imem_addr sequence 0,4,8,12; inst_pc matches; inst_valid first high one cycle after the first ack.
- inst_ready=0, ack always 1, FIFO_DEPTH=4 → exactly 4 pushes; imem_req deasserts; fifo_count=4; then one pop → exactly one new request at address 16.
- br_taken with br_pc=0x20, br_imm=0xFFFE and the buffer holding 3 entries → next edge fifo_count=0 and next imem_addr=0x1C.
- Redirect while in WAIT (ack delayed 3 cycles) → imem_addr held until ack; acked word not pushed; next request at the target; inst_pc of the first popped instruction equals the target.
- br_taken and imem_ack in the same cycle → no push; state IDLE; next request at the target.
- rst_n pulsed low mid-WAIT, and FETCH_PERF_CNT_EN build with 5 fetches then a redirect discarding 2 entries plus 1 in flight → after reset imem_req=0 asynchronously and the restart is at RESET_PC; perf_fetched=5, perf_flushed=3.
